// File: rtl/tmds_deserializer.sv
// TMDS receiver on the bit clock: aligns 10-bit words to the clock-lane rise, emits words once locked.
// Define TMDS_DECODE_EN to add control-token / 8-bit data decode; otherwise de/ctrl/pixel are 0.
module tmds_deserializer #(
    parameter int LOCK_COUNT = 8,
    parameter int MISS_LIMIT = 2
) (
    input  logic        clk_pixel_x10,
    input  logic        reset,
    input  logic [2:0]  tmds_in,
    input  logic        tmds_clock_in,
    output logic [9:0]  word0,
    output logic [9:0]  word1,
    output logic [9:0]  word2,
    output logic        word_valid,
    output logic        locked,
    output logic        align_err,
    output logic        de,
    output logic [1:0]  ctrl,
    output logic [23:0] pixel
);
    localparam logic [3:0] LC = 4'(LOCK_COUNT);
    localparam logic [3:0] ML = 4'(MISS_LIMIT);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    logic [2:0]      in_q;
    logic            clk_q, clk_prev_q;
    logic [2:0][9:0] sh_q, word_q;
    logic [3:0]      bit_cnt_q, bit_cnt_d, good_cnt_q, miss_cnt_q;
    state_t          state_q;
    logic            word_valid_q, locked_q, align_err_q;
    logic            rise, expect_b, good, bad, lose, capture;

    always_ff @(posedge clk_pixel_x10 or posedge reset) begin
        if (reset) begin
            in_q       <= '0;
            clk_q      <= 1'b0;
            clk_prev_q <= 1'b0;
            sh_q       <= '0;
        end else begin
            in_q       <= tmds_in;
            clk_q      <= tmds_clock_in;
            clk_prev_q <= clk_q;
            for (int n = 0; n < 3; n++) sh_q[n] <= {in_q[n], sh_q[n][9:1]};
        end
    end

    always_comb begin
        rise     = clk_q & ~clk_prev_q;
        expect_b = (bit_cnt_q == 4'd0);
        good     = rise & expect_b;
        bad      = rise ^ expect_b;
        lose     = (state_q == LOCKED) && bad && (miss_cnt_q + 4'd1 == ML);
        capture  = (state_q == LOCKED) && expect_b && !lose;
        // LOCKED keeps its phase through stray rises; only HUNT/VERIFY re-phase.
        if (rise && state_q != LOCKED) bit_cnt_d = 4'd1;
        else                           bit_cnt_d = (bit_cnt_q == 4'd9) ? 4'd0 : bit_cnt_q + 4'd1;
    end

    always_ff @(posedge clk_pixel_x10 or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            bit_cnt_q   <= '0;
            good_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            align_err_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (rise) begin
                        state_q    <= VERIFY;
                        good_cnt_q <= '0;
                    end
                end
                VERIFY: begin
                    if (good) begin
                        good_cnt_q <= good_cnt_q + 4'd1;
                        if (good_cnt_q + 4'd1 == LC) begin
                            state_q    <= LOCKED;
                            miss_cnt_q <= '0;
                            locked_q   <= 1'b1;
                        end
                    end else if (bad) begin
                        align_err_q <= 1'b1;
                        good_cnt_q  <= '0;
                        if (!rise) state_q <= HUNT;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        miss_cnt_q <= '0;
                    end else if (bad) begin
                        align_err_q <= 1'b1;
                        miss_cnt_q  <= miss_cnt_q + 4'd1;
                        if (lose) begin
                            state_q  <= HUNT;
                            locked_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pixel_x10 or posedge reset) begin
        if (reset) begin
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= capture;
            if (capture) word_q <= sh_q;
        end
    end

`ifdef TMDS_DECODE_EN
    function automatic logic [7:0] tmds_dec(input logic [9:0] q);
        logic [7:0] m, d;
        m    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = m[0];
        for (int i = 1; i < 8; i++) d[i] = q[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
        return d;
    endfunction

    logic [2:0]      is_tok;
    logic [2:0][1:0] tok_ctrl;
    logic [2:0][7:0] dec_d;
    logic            de_q;
    logic [1:0]      ctrl_q;
    logic [23:0]     pixel_q;

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            is_tok[n]   = 1'b1;
            tok_ctrl[n] = 2'b00;
            case (sh_q[n])
                10'b1101010100: tok_ctrl[n] = 2'b00;
                10'b0010101011: tok_ctrl[n] = 2'b01;
                10'b0101010100: tok_ctrl[n] = 2'b10;
                10'b1010101011: tok_ctrl[n] = 2'b11;
                default:        is_tok[n]   = 1'b0;
            endcase
            dec_d[n] = tmds_dec(sh_q[n]);
        end
    end

    always_ff @(posedge clk_pixel_x10 or posedge reset) begin
        if (reset) begin
            de_q    <= 1'b0;
            ctrl_q  <= 2'b00;
            pixel_q <= '0;
        end else if (capture) begin
            de_q <= ~|is_tok;
            if (~|is_tok)      pixel_q <= dec_d;
            else if (is_tok[0]) ctrl_q <= tok_ctrl[0];
        end
    end

    assign de    = de_q;
    assign ctrl  = ctrl_q;
    assign pixel = pixel_q;
`else
    assign de    = 1'b0;
    assign ctrl  = 2'b00;
    assign pixel = 24'd0;
`endif

    assign word0      = word_q[0];
    assign word1      = word_q[1];
    assign word2      = word_q[2];
    assign word_valid = word_valid_q;
    assign locked     = locked_q;
    assign align_err  = align_err_q;
endmodule

// File: tb/tb_tmds_deserializer.sv
// Bench for tmds_deserializer: time-based alignment model over the input history, randomized lane words.
module tb_tmds_deserializer;
    localparam int LC = 8;
    localparam int ML = 2;
    localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

    logic        clk = 1'b0, rst = 1'b1, tclk = 1'b0;
    logic [2:0]  tin = '0;
    logic [9:0]  w0, w1, w2;
    logic        wv, lk, ae, de;
    logic [1:0]  ctrl;
    logic [23:0] pixel;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    tmds_deserializer #(.LOCK_COUNT(LC), .MISS_LIMIT(ML)) dut (
        .clk_pixel_x10(clk), .reset(rst), .tmds_in(tin), .tmds_clock_in(tclk),
        .word0(w0), .word1(w1), .word2(w2), .word_valid(wv), .locked(lk),
        .align_err(ae), .de(de), .ctrl(ctrl), .pixel(pixel)
    );

    // Model: boundaries are edges a multiple of 10 after the last accepted rise.
    int          mmode, good_n, miss_n;
    longint      k = 0, last_b = 0;
    logic        mc1, mc2;
    logic [2:0]  hist [12];
    logic [9:0]  e_w [3];
    logic        e_vld, e_err, e_de;
    logic [1:0]  e_ctrl;
    logic [23:0] e_pix;
    int dut_vld, dut_err, m_vld, m_err;

    function automatic logic [2:0] tokv(input logic [9:0] q);
        case (q)
            10'b1101010100: return 3'b100;
            10'b0010101011: return 3'b101;
            10'b0101010100: return 3'b110;
            10'b1010101011: return 3'b111;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] ddec(input logic [9:0] q);
        logic [7:0] m, d;
        m    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = m[0];
        for (int i = 1; i < 8; i++) d[i] = (m[i] ^ m[i-1]) ^ ~q[8];
        return d;
    endfunction

    task automatic model_reset;
        mmode = M_HUNT; good_n = 0; miss_n = 0; mc1 = 0; mc2 = 0; last_b = k;
        for (int i = 0; i < 12; i++) hist[i] = '0;
        for (int n = 0; n < 3; n++) e_w[n] = '0;
        e_vld = 0; e_err = 0; e_de = 0; e_ctrl = '0; e_pix = '0;
    endtask

    task automatic model_step(input logic c, input logic [2:0] d);
        logic rise, expb, bad, lose;
        logic [2:0] t0, t1, t2;
        rise  = mc1 & ~mc2;
        expb  = ((k - last_b) % 10) == 0;
        bad   = rise != expb;
        lose  = (mmode == M_LOCKED) && bad && (miss_n + 1 == ML);
        e_vld = (mmode == M_LOCKED) && expb && !lose;
        e_err = 0;
        if (e_vld) begin
            for (int n = 0; n < 3; n++)
                for (int j = 0; j < 10; j++) e_w[n][j] = hist[10-j][n];
            t0 = tokv(e_w[0]); t1 = tokv(e_w[1]); t2 = tokv(e_w[2]);
            e_de = !(t0[2] | t1[2] | t2[2]);
            if (e_de)       e_pix  = {ddec(e_w[2]), ddec(e_w[1]), ddec(e_w[0])};
            else if (t0[2]) e_ctrl = t0[1:0];
        end
        case (mmode)
            M_HUNT: if (rise) begin mmode = M_VERIFY; good_n = 0; last_b = k; end
            M_VERIFY: begin
                if (rise && expb) begin
                    good_n++;
                    if (good_n == LC) begin mmode = M_LOCKED; miss_n = 0; end
                end else if (bad) begin
                    e_err = 1;
                    if (rise) begin good_n = 0; last_b = k; end
                    else mmode = M_HUNT;
                end
            end
            default: begin
                if (rise && expb) miss_n = 0;
                else if (bad) begin
                    e_err = 1; miss_n++;
                    if (miss_n == ML) mmode = M_HUNT;
                end
            end
        endcase
        for (int i = 11; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d; mc2 = mc1; mc1 = c; k++;
    endtask

    task automatic cyc(input logic c, input logic [2:0] d);
        @(negedge clk); tclk = c; tin = d;
        @(posedge clk); if (!rst) model_step(c, d);
        #1;
        if (wv) dut_vld++;
        if (e_vld) m_vld++;
        if (ae) dut_err++;
        if (e_err) m_err++;
    endtask

    task automatic send_period(input int len, input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [2:0] dd;
        for (int i = 0; i < len; i++) begin
            dd = '0;
            if (i < 10) dd = {c[i], b[i], a[i]};
            cyc(i < (len + 1) / 2, dd);
        end
    endtask

    task automatic hold_reset;
        @(negedge clk); rst = 1; tclk = 0; tin = '0; model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        dut_vld = 0; dut_err = 0; m_vld = 0; m_err = 0;
    endtask

    task automatic test_reset;
        rst = 1; model_reset();
        repeat (3) @(negedge clk);
        checks++; if ({wv, lk, ae, de, ctrl} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {wv, lk, ae, de, ctrl}); end
        checks++; if ({w2, w1, w0} !== 30'd0) begin errors++; $display("FAIL reset_words: got %h want 0", {w2, w1, w0}); end
        checks++; if (pixel !== 24'd0) begin errors++; $display("FAIL reset_pixel: got %h want 0", pixel); end
        rst = 0;
        dut_vld = 0; dut_err = 0; m_vld = 0; m_err = 0;
    endtask

    task automatic test_lock;
        logic [9:0] a, b, c;
        int n, first_lk, first_wv, last_wv;
        a = 10'h3A5; b = 10'h15A; c = 10'h2C3;
        n = 0; first_lk = -1; first_wv = -1; last_wv = -1;
        for (int p = 0; p < LC + 4; p++)
            for (int i = 0; i < 10; i++) begin
                cyc(i < 5, {c[i], b[i], a[i]});
                checks++; if (wv !== e_vld) begin errors++; $display("FAIL lock_wv@%0d: got %b want %b", n, wv, e_vld); end
                checks++; if (lk !== (mmode == M_LOCKED)) begin errors++; $display("FAIL lock_lk@%0d: got %b want %b", n, lk, mmode == M_LOCKED); end
                if (wv) begin
                    if (first_wv < 0) first_wv = n;
                    else begin
                        checks++; if (n - last_wv != 10) begin errors++; $display("FAIL lock_wv_gap: got %0d want 10", n - last_wv); end
                    end
                    last_wv = n;
                end
                if (lk && first_lk < 0) first_lk = n;
                n++;
            end
        checks++; if (first_lk != 10 * LC + 1) begin errors++; $display("FAIL lock_time: got %0d want %0d", first_lk, 10 * LC + 1); end
        checks++; if (first_wv != 10 * (LC + 1) + 1) begin errors++; $display("FAIL first_wv_time: got %0d want %0d", first_wv, 10 * (LC + 1) + 1); end
        checks++; if ({w2, w1, w0} !== {c, b, a}) begin errors++; $display("FAIL lock_words: got %h want %h", {w2, w1, w0}, {c, b, a}); end
    endtask

    task automatic test_miss;
        dut_err = 0; m_err = 0;
        send_period(20, 10'($urandom), 10'($urandom), 10'($urandom));
        repeat (2) send_period(10, 10'($urandom), 10'($urandom), 10'($urandom));
        checks++; if (dut_err != 1) begin errors++; $display("FAIL miss_one_err: got %0d want 1", dut_err); end
        checks++; if (lk !== 1'b1) begin errors++; $display("FAIL miss_one_lk: got %b want 1", lk); end
        dut_err = 0; m_err = 0;
        send_period(9, 10'($urandom), 10'($urandom), 10'($urandom));
        send_period(10, 10'($urandom), 10'($urandom), 10'($urandom));
        checks++; if (dut_err != 2 || m_err != 2) begin errors++; $display("FAIL miss_two_err: got %0d want 2 (model %0d)", dut_err, m_err); end
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL miss_two_lk: got %b want 0", lk); end
        dut_vld = 0;
        repeat (3) send_period(10, 10'($urandom), 10'($urandom), 10'($urandom));
        checks++; if (dut_vld != 0) begin errors++; $display("FAIL miss_wv_stop: got %0d strobes want 0", dut_vld); end
    endtask

    task automatic test_rephase;
        hold_reset();
        repeat (5) send_period(10, 10'($urandom), 10'($urandom), 10'($urandom));
        send_period(7, 10'($urandom), 10'($urandom), 10'($urandom));
        repeat (8) send_period(10, 10'($urandom), 10'($urandom), 10'($urandom));
        checks++; if (dut_err != 1) begin errors++; $display("FAIL rephase_err: got %0d want 1", dut_err); end
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL rephase_early_lk: got %b want 0", lk); end
        send_period(10, 10'($urandom), 10'($urandom), 10'($urandom));
        checks++; if (lk !== 1'b1) begin errors++; $display("FAIL rephase_lk: got %b want 1", lk); end
        checks++; if (dut_vld != m_vld) begin errors++; $display("FAIL rephase_wv_cnt: got %0d want %0d", dut_vld, m_vld); end
    endtask

    task automatic test_decode;
        hold_reset();
        repeat (LC + 3) send_period(10, 10'h154, 10'h354, 10'h354);
`ifdef TMDS_DECODE_EN
        checks++; if ({de, ctrl} !== 3'b010) begin errors++; $display("FAIL dec_token: got de=%b ctrl=%b want de=0 ctrl=10", de, ctrl); end
`else
        checks++; if ({de, ctrl, pixel} !== 27'd0) begin errors++; $display("FAIL dec_tied_tok: got %h want 0", {de, ctrl, pixel}); end
`endif
        repeat (2) send_period(10, 10'h1FF, 10'h1FF, 10'h1FF);
`ifdef TMDS_DECODE_EN
        checks++; if ({de, ctrl} !== 3'b110) begin errors++; $display("FAIL dec_data_de: got de=%b ctrl=%b want de=1 ctrl=10", de, ctrl); end
        checks++; if (pixel !== 24'h010101) begin errors++; $display("FAIL dec_pixel: got %h want 010101", pixel); end
`else
        checks++; if ({de, ctrl, pixel} !== 27'd0) begin errors++; $display("FAIL dec_tied_data: got %h want 0", {de, ctrl, pixel}); end
`endif
    endtask

    task automatic test_mid_reset;
        hold_reset();
        repeat (LC + 3) send_period(10, 10'($urandom), 10'($urandom), 10'($urandom));
        checks++; if (lk !== 1'b1) begin errors++; $display("FAIL midrst_prelock: got %b want 1", lk); end
        for (int i = 0; i < 4; i++) cyc(1'b1, 3'($urandom));
        @(negedge clk); rst = 1; tclk = 0; tin = '0;
        #1;
        checks++; if ({wv, lk, ae, de, ctrl} !== 6'b0) begin errors++; $display("FAIL midrst_flags: got %b want 000000", {wv, lk, ae, de, ctrl}); end
        checks++; if ({w2, w1, w0, pixel} !== 54'd0) begin errors++; $display("FAIL midrst_data: got %h want 0", {w2, w1, w0, pixel}); end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0; dut_vld = 0; m_vld = 0;
        repeat (LC) send_period(10, 10'($urandom), 10'($urandom), 10'($urandom));
        checks++; if (dut_vld != 0) begin errors++; $display("FAIL midrst_no_wv: got %0d strobes want 0", dut_vld); end
        repeat (3) send_period(10, 10'($urandom), 10'($urandom), 10'($urandom));
        checks++; if (dut_vld != m_vld || lk !== 1'b1) begin errors++; $display("FAIL midrst_relock: got %0d strobes lk=%b want %0d lk=1", dut_vld, lk, m_vld); end
    endtask

    task automatic test_back_to_back;
        int len, pick;
        logic [9:0] a, b, c;
        logic [2:0] dd;
        hold_reset();
        for (int p = 0; p < 150; p++) begin
            len = 10;
            if ($urandom_range(0, 14) == 0) begin
                pick = $urandom_range(0, 4);
                len  = (pick == 0) ? 7 : (pick == 1) ? 9 : (pick == 2) ? 11 : (pick == 3) ? 13 : 20;
            end
            a = 10'($urandom); b = 10'($urandom); c = 10'($urandom);
            if ($urandom_range(0, 9) == 0) a = 10'h2AB;
            for (int i = 0; i < len; i++) begin
                dd = '0;
                if (i < 10) dd = {c[i], b[i], a[i]};
                cyc(i < (len + 1) / 2, dd);
                checks++; if ({wv, lk, ae} !== {e_vld, mmode == M_LOCKED, e_err})
                    begin errors++; $display("FAIL rnd_flags p%0d c%0d: got %b want %b", p, i, {wv, lk, ae}, {e_vld, mmode == M_LOCKED, e_err}); end
                checks++; if ({w2, w1, w0} !== {e_w[2], e_w[1], e_w[0]})
                    begin errors++; $display("FAIL rnd_words p%0d c%0d: got %h want %h", p, i, {w2, w1, w0}, {e_w[2], e_w[1], e_w[0]}); end
`ifdef TMDS_DECODE_EN
                checks++; if ({de, ctrl, pixel} !== {e_de, e_ctrl, e_pix})
                    begin errors++; $display("FAIL rnd_decode p%0d c%0d: got %h want %h", p, i, {de, ctrl, pixel}, {e_de, e_ctrl, e_pix}); end
`else
                checks++; if ({de, ctrl, pixel} !== 27'd0)
                    begin errors++; $display("FAIL rnd_tied p%0d c%0d: got %h want 0", p, i, {de, ctrl, pixel}); end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_miss();
        test_rephase();
        test_decode();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
